// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receiver: FSM state encoding and frame constants.
// The top (ps2_rx) optionally enforces odd parity when PS2_RX_PARITY_CHECK_EN is defined.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int          FRAME_DATA_BITS = 8;
  localparam logic [7:0]  BREAK_CODE      = 8'hF0;
  localparam logic [7:0]  EXT_CODE        = 8'hE0;

endpackage

// File: rtl/ps2_clk_filter.sv
// Pin conditioning for PS/2: synchronises both pins, debounces ps2_clk and
// emits a one-cycle fall pulse when the filtered clock goes 1->0.
module ps2_clk_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s,
  output logic clk_filt
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic [FW-1:0]          filt_cnt;
  logic                   clk_s;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // The filtered level flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      filt_cnt <= '0;
      clk_filt <= 1'b1;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == F_LAST) begin
        filt_cnt <= '0;
        clk_filt <= clk_s;
        fall     <= clk_filt & ~clk_s;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Define PS2_RX_PARITY_CHECK_EN to drop frames whose parity is wrong.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_out,
  output logic       key_pressed,
  output logic       frame_err,
  output ps2_state_e state_dbg
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LIMIT  = TW'(TIMEOUT_CYCLES);
  localparam logic [2:0]    BIT_LAST = 3'(FRAME_DATA_BITS - 1);

`ifdef PS2_RX_PARITY_CHECK_EN
  localparam bit PARITY_CHECK = 1'b1;
`else
  localparam bit PARITY_CHECK = 1'b0;
`endif

  // Valid/ready does not apply here: key_pressed and frame_err are single-cycle
  // strobes with no backpressure; data_out is stable from key_pressed until the next one.

  logic            fall;
  logic            data_s;
  logic            clk_filt;
  ps2_state_e      state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            par_acc;
  logic [TW-1:0]   tcnt;

  ps2_clk_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_filter (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall     (fall),
    .data_s   (data_s),
    .clk_filt (clk_filt)
  );

  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      par_acc     <= 1'b0;
      tcnt        <= '0;
      data_out    <= 8'h00;
      key_pressed <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      key_pressed <= 1'b0;
      frame_err   <= 1'b0;

      case (state)
        ST_IDLE: begin
          tcnt <= '0;
          if (fall && !data_s) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
            par_acc <= 1'b0;
          end
        end
        ST_DATA: begin
          if (fall) begin
            shift   <= {data_s, shift[7:1]};
            par_acc <= par_acc ^ data_s;
            tcnt    <= '0;
            if (bit_cnt == BIT_LAST) state <= ST_PARITY;
            else                     bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (fall) begin
            par_acc <= par_acc ^ data_s;
            tcnt    <= '0;
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (fall) begin
            tcnt  <= '0;
            state <= ST_IDLE;
            // With odd parity the XOR over data plus parity bit must be 1.
            if (data_s && (!PARITY_CHECK || par_acc)) begin
              data_out    <= shift;
              key_pressed <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A fall in the same cycle as expiry wins because this only runs without one.
      if (state != ST_IDLE && !fall) begin
        if (tcnt == T_LIMIT) begin
          frame_err <= 1'b1;
          state     <= ST_IDLE;
          tcnt      <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

  logic unused_ok;
  assign unused_ok = clk_filt;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: good frames, back-to-back, bad parity/stop, timeout,
// clock glitch and reset mid-frame. Honours PS2_RX_PARITY_CHECK_EN when defined.
module tb_ps2_rx;
  import ps2_pkg::*;

  localparam int HALF    = 40;
  localparam int TIMEOUT = 300;

  logic       clock;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data_out;
  logic       key_pressed;
  logic       frame_err;
  ps2_state_e state_dbg;

  int checks   = 0;
  int failures = 0;
  int kp_cnt   = 0;
  int err_cnt  = 0;

  ps2_rx #(
    .SYNC_STAGES    (2),
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .data_out    (data_out),
    .key_pressed (key_pressed),
    .frame_err   (frame_err),
    .state_dbg   (state_dbg)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // strobe monitor: a one-cycle pulse counts exactly once
  always @(negedge clock) begin
    if (key_pressed) kp_cnt <= kp_cnt + 1;
    if (frame_err)   err_cnt <= err_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic par, input logic stop);
    return {stop, par, b, 1'b0};
  endfunction

  // drives the first n bits of a frame; ps2_clk ends high, ps2_data returns to idle
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic frame_and_check(input string tag, input logic [7:0] b, input logic par,
                                 input logic stop, input int exp_kp, input int exp_err,
                                 input logic [7:0] exp_data);
    int kp0, er0;
    kp0 = kp_cnt;
    er0 = err_cnt;
    send_bits(make_frame(b, par, stop), 11);
    wait_cycles(2);
    check_val({tag, "_kp"},   32'(kp_cnt - kp0), 32'(exp_kp));
    check_val({tag, "_err"},  32'(err_cnt - er0), 32'(exp_err));
    check_val({tag, "_data"}, 32'(data_out), 32'(exp_data));
  endtask

  initial begin
    int kp0, er0, busy;
    logic [7:0] exp_q[$];

    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(5);
    check_val("rst_data",  32'(data_out), 32'h00);
    check_val("rst_kp",    32'(key_pressed), 32'h0);
    check_val("rst_err",   32'(frame_err), 32'h0);
    check_val("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    reset = 1'b0;
    wait_cycles(20);

    frame_and_check("f1d", 8'h1D, 1'b1, 1'b1, 1, 0, 8'h1D);

`ifdef PS2_RX_PARITY_CHECK_EN
    frame_and_check("badpar", 8'h75, 1'b1, 1'b1, 0, 1, 8'h1D);
`else
    frame_and_check("badpar", 8'h75, 1'b1, 1'b1, 1, 0, 8'h75);
`endif

    // back-to-back frames, expected bytes queued and compared per strobe
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h75);
    kp0 = kp_cnt;
    er0 = err_cnt;
    send_bits(make_frame(8'hF0, 1'b1, 1'b1), 11);
    check_val("b2b_first", 32'(data_out), 32'(exp_q.pop_front()));
    send_bits(make_frame(8'h75, 1'b0, 1'b1), 11);
    wait_cycles(2);
    check_val("b2b_second", 32'(data_out), 32'(exp_q.pop_front()));
    check_val("b2b_kp",  32'(kp_cnt - kp0), 32'd2);
    check_val("b2b_err", 32'(err_cnt - er0), 32'd0);

    frame_and_check("badstop", 8'h1D, 1'b1, 1'b0, 0, 1, 8'h75);
    frame_and_check("f29", 8'h29, 1'b0, 1'b1, 1, 0, 8'h29);

    // timeout: start + 4 data bits of 0x1C, then clock stops
    kp0 = kp_cnt;
    er0 = err_cnt;
    send_bits(make_frame(8'h1C, 1'b0, 1'b1), 5);
    wait_cycles(150);
    check_val("to_early", 32'(err_cnt - er0), 32'd0);
    for (int i = 0; i < 400 && err_cnt == er0; i++) wait_cycles(1);
    wait_cycles(2);
    check_val("to_err",   32'(err_cnt - er0), 32'd1);
    check_val("to_kp",    32'(kp_cnt - kp0), 32'd0);
    check_val("to_state", 32'(state_dbg), 32'(ST_IDLE));
    check_val("to_data",  32'(data_out), 32'h29);
    frame_and_check("f1c", 8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C);

    // short glitch on ps2_clk with data low must not start a frame
    kp0 = kp_cnt;
    er0 = err_cnt;
    busy = 0;
    ps2_data = 1'b0;
    wait_cycles(10);
    ps2_clk = 1'b0;
    wait_cycles(3);
    ps2_clk = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wait_cycles(1);
      if (state_dbg != ST_IDLE) busy++;
    end
    ps2_data = 1'b1;
    check_val("glitch_state", 32'(busy), 32'd0);
    check_val("glitch_err",   32'(err_cnt - er0), 32'd0);
    check_val("glitch_kp",    32'(kp_cnt - kp0), 32'd0);

    // reset mid-frame, then a clean frame resynchronises
    send_bits(make_frame(8'h5A, 1'b1, 1'b1), 4);
    check_val("mid_busy", 32'(state_dbg), 32'(ST_DATA));
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(1);
    check_val("mid_rst_data",  32'(data_out), 32'h00);
    check_val("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    wait_cycles(50);
    frame_and_check("f5a", 8'h5A, 1'b1, 1'b1, 1, 0, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
